alu_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one simple_alu instance between NUM_REQ requesters.
- Each requester presents a parallel command: 2-bit opcode plus operands A and B.
- The scheduler arbitrates, serializes the winning command onto the ALU's 3-beat opcode_valid/opcode/data protocol, waits for done, and returns result/overflow to the winner with a one-cycle response pulse.
- Sits between the client blocks and simple_alu; it is the only driver of the ALU inputs.

---
 rtl/alu_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_alu_rr_scheduler.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one simple_alu among NUM_REQ requesters.
// Define ALU_TIMEOUT_EN to bound the wait for alu_done (TIMEOUT_CYCLES).
module alu_rr_scheduler #(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [2*NUM_REQ-1:0]          req_opcode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic                          rsp_error,
  output logic                          busy,
  output logic                          alu_opcode_valid,
  output logic                          alu_opcode,
  output logic [DATA_WIDTH-1:0]         alu_data,
  input  logic                          alu_done,
  input  logic [DATA_WIDTH-1:0]         alu_result,
  input  logic                          alu_overflow
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;
`ifdef ALU_TIMEOUT_EN
  localparam int CB = $clog2(TIMEOUT_CYCLES + 1);
  localparam int TW = (CB > 8) ? CB : 8;
`endif

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("alu_rr_scheduler: unsupported parameter values");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_BEAT_A,
    S_BEAT_B,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state, w_state;
  logic [IW-1:0]         r_ptr, w_ptr;
  logic [IW-1:0]         r_idx, w_idx;
  logic [1:0]            r_op, w_op;
  logic [DATA_WIDTH-1:0] r_a, w_a;
  logic [DATA_WIDTH-1:0] r_b, w_b;
  logic [NUM_REQ-1:0]    r_gnt, w_gnt;
  logic [NUM_REQ-1:0]    r_rsp_v, w_rsp_v;
  logic [DATA_WIDTH-1:0] r_res, w_res;
  logic                  r_ovf, w_ovf;
  logic                  r_err, w_err;
  logic                  r_busy, w_busy;
  logic                  r_aov, w_aov;
  logic                  r_aop, w_aop;
  logic [DATA_WIDTH-1:0] r_adat, w_adat;
`ifdef ALU_TIMEOUT_EN
  logic [TW-1:0]         r_cnt, w_cnt;
`endif

  logic                  w_hit;
  logic [IW-1:0]         w_sel;
  logic [SW-1:0]         w_pos;
  logic [NUM_REQ-1:0]    w_sel_oh;
  logic [NUM_REQ-1:0]    w_idx_oh;
  logic [1:0]            w_sel_op;
  logic [DATA_WIDTH-1:0] w_sel_a;
  logic [DATA_WIDTH-1:0] w_sel_b;
  logic [IW-1:0]         w_ptr_inc;

  // First requester at or after the pointer, wrapping modulo NUM_REQ
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_pos = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pos = {1'b0, r_ptr} + SW'(k);
      if (w_pos >= SW'(NUM_REQ)) begin
        w_pos = w_pos - SW'(NUM_REQ);
      end
      if (!w_hit && req[w_pos[IW-1:0]]) begin
        w_hit = 1'b1;
        w_sel = w_pos[IW-1:0];
      end
    end
  end

  always_comb begin
    w_sel_oh = '0;
    w_idx_oh = '0;
    w_sel_op = '0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel == IW'(i)) begin
        w_sel_oh[i] = 1'b1;
        w_sel_op    = req_opcode[2*i +: 2];
        w_sel_a     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_b     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
      end
      if (r_idx == IW'(i)) begin
        w_idx_oh[i] = 1'b1;
      end
    end
  end

  assign w_ptr_inc = (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;

  // Outputs are registered: each is computed for the state being entered
  always_comb begin
    w_state = r_state;
    w_ptr   = r_ptr;
    w_idx   = r_idx;
    w_op    = r_op;
    w_a     = r_a;
    w_b     = r_b;
    w_gnt   = r_gnt;
    w_rsp_v = '0;
    w_res   = '0;
    w_ovf   = 1'b0;
    w_err   = 1'b0;
    w_aov   = 1'b0;
    w_aop   = 1'b0;
    w_adat  = '0;
`ifdef ALU_TIMEOUT_EN
    w_cnt   = r_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_state = S_HDR;
          w_idx   = w_sel;
          w_op    = w_sel_op;
          w_a     = w_sel_a;
          w_b     = w_sel_b;
          w_gnt   = w_sel_oh;
          w_aov   = 1'b1;
        end
      end
      S_HDR: begin
        w_state = S_BEAT_A;
        w_aov   = 1'b1;
        w_aop   = r_op[0];
        w_adat  = r_a;
      end
      S_BEAT_A: begin
        w_state = S_BEAT_B;
        w_aov   = 1'b1;
        w_aop   = r_op[1];
        w_adat  = r_b;
      end
      S_BEAT_B: begin
        w_state = S_WAIT;
`ifdef ALU_TIMEOUT_EN
        w_cnt   = '0;
`endif
      end
      S_WAIT: begin
        if (alu_done) begin
          w_state = S_RESP;
          w_rsp_v = w_idx_oh;
          w_res   = alu_result;
          w_ovf   = alu_overflow;
        end
`ifdef ALU_TIMEOUT_EN
        else if (r_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_state = S_RESP;
          w_rsp_v = w_idx_oh;
          w_err   = 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
`endif
      end
      S_RESP: begin
        w_state = S_IDLE;
        w_gnt   = '0;
        w_ptr   = w_ptr_inc;
      end
      default: begin
        w_state = S_IDLE;
        w_gnt   = '0;
      end
    endcase
    w_busy = (w_state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_idx   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_gnt   <= '0;
      r_rsp_v <= '0;
      r_res   <= '0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_aov   <= 1'b0;
      r_aop   <= 1'b0;
      r_adat  <= '0;
`ifdef ALU_TIMEOUT_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_ptr   <= w_ptr;
      r_idx   <= w_idx;
      r_op    <= w_op;
      r_a     <= w_a;
      r_b     <= w_b;
      r_gnt   <= w_gnt;
      r_rsp_v <= w_rsp_v;
      r_res   <= w_res;
      r_ovf   <= w_ovf;
      r_err   <= w_err;
      r_busy  <= w_busy;
      r_aov   <= w_aov;
      r_aop   <= w_aop;
      r_adat  <= w_adat;
`ifdef ALU_TIMEOUT_EN
      r_cnt   <= w_cnt;
`endif
    end
  end

  assign gnt              = r_gnt;
  assign rsp_valid        = r_rsp_v;
  assign rsp_result       = r_res;
  assign rsp_overflow     = r_ovf;
  assign rsp_error        = r_err;
  assign busy             = r_busy;
  assign alu_opcode_valid = r_aov;
  assign alu_opcode       = r_aop;
  assign alu_data         = r_adat;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: behavioural ALU, vector table,
// corner-case sequences and a randomized round-robin reference model.
`timescale 1ns/1ps
module tb_alu_rr_scheduler;
  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req;
  logic [2*N-1:0] req_opcode;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   gnt;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_result;
  logic           rsp_overflow;
  logic           rsp_error;
  logic           busy;
  logic           alu_opcode_valid;
  logic           alu_opcode;
  logic [W-1:0]   alu_data;
  logic           alu_done;
  logic [W-1:0]   alu_result;
  logic           alu_overflow;

  always #5 clk = ~clk;

  alu_rr_scheduler #(
    .DATA_WIDTH(W),
    .NUM_REQ(N),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .req_opcode(req_opcode),
    .req_a(req_a),
    .req_b(req_b),
    .gnt(gnt),
    .rsp_valid(rsp_valid),
    .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow),
    .rsp_error(rsp_error),
    .busy(busy),
    .alu_opcode_valid(alu_opcode_valid),
    .alu_opcode(alu_opcode),
    .alu_data(alu_data),
    .alu_done(alu_done),
    .alu_result(alu_result),
    .alu_overflow(alu_overflow)
  );

  int checks = 0;
  int failures = 0;

  // ALU semantics: {overflow, result}
  function automatic logic [W:0] alu_fn(input logic [1:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {a < b, a - b};
      2'b10:   r = {1'b0, {(W-1){1'b0}}, ^{a, b}};
      default: r = {1'b0, {(W-2){1'b0}}, a > b, a == b};
    endcase
    return r;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural simple_alu: 3 beats in, done after alu_lat extra cycles
  bit           alu_en = 1'b1;
  bit           alu_glitch = 1'b0;
  int           alu_lat = 2;
  logic [W:0]   beat_log[$];
  initial begin
    logic         s_ov, s_op, s_rst;
    logic [W-1:0] s_d;
    logic [W:0]   r;
    logic [1:0]   m_op;
    logic [W-1:0] m_a, m_b;
    int           nb, pend;
    nb = 0;
    pend = -1;
    m_op = '0;
    m_a = '0;
    m_b = '0;
    alu_done = 1'b0;
    alu_result = '0;
    alu_overflow = 1'b0;
    forever begin
      @(negedge clk);
      s_ov = alu_opcode_valid;
      s_op = alu_opcode;
      s_d  = alu_data;
      @(posedge clk);
      s_rst = reset_n;
      #1;
      alu_done = 1'b0;
      alu_result = '0;
      alu_overflow = 1'b0;
      if (!s_rst) begin
        nb = 0;
        pend = -1;
      end else begin
        if (s_ov) begin
          beat_log.push_back({s_op, s_d});
          if (nb == 1) begin m_op[0] = s_op; m_a = s_d; end
          if (nb == 2) begin m_op[1] = s_op; m_b = s_d; end
          nb++;
          if (nb == 3) begin
            nb = 0;
            pend = alu_lat;
          end else if (alu_glitch) begin
            alu_done = 1'b1;
            alu_result = '1;
            alu_overflow = 1'b1;
          end
        end
        if (pend == 0) begin
          pend = -1;
          if (alu_en) begin
            r = alu_fn(m_op, m_a, m_b);
            alu_done = 1'b1;
            alu_result = r[W-1:0];
            alu_overflow = r[W];
          end
        end else if (pend > 0) begin
          pend--;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_cmd(input int i, input logic [1:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_opcode[2*i +: 2] = op;
    req_a[W*i +: W] = a;
    req_b[W*i +: W] = b;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_rsp(input int maxc, output int ncyc);
    ncyc = 0;
    while (rsp_valid == '0 && ncyc < maxc) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  task automatic wait_gnt(input int maxc, output int ncyc);
    ncyc = 0;
    while (gnt == '0 && ncyc < maxc) begin
      @(negedge clk);
      ncyc++;
    end
  endtask

  typedef struct {
    int         idx;
    logic [1:0] op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic       ovf;
  } vec_t;

  task automatic run_one(input vec_t v, input string tag);
    int nc;
    req = '0;
    set_cmd(v.idx, v.op, v.a, v.b);
    req[v.idx] = 1'b1;
    @(negedge clk);
    wait_rsp(40, nc);
    check({tag, "_rsp"},
          {rsp_valid, gnt, rsp_result, rsp_overflow, rsp_error},
          {oh(v.idx), oh(v.idx), v.res, v.ovf, 1'b0});
    req = '0;
    @(negedge clk);
    check({tag, "_gap"}, {gnt, rsp_valid, busy}, '0);
  endtask

  vec_t tbl[8];

  initial begin
    int         nc, bad, exp_i, ptr_m, gcur, gcyc, lat_cur, ntx;
    logic [W:0] r;
    logic [N-1:0] prev_req, exp_g;
    bit         gap_chk;
    bit         act[N];
    logic [1:0] c_op[N];
    logic [W-1:0] c_a[N];
    logic [W-1:0] c_b[N];

    tbl[0] = '{0, 2'b00, 8'h12, 8'h34, 8'h46, 1'b0};
    tbl[1] = '{0, 2'b01, 8'h05, 8'h0A, 8'hFB, 1'b1};
    tbl[2] = '{1, 2'b00, 8'hF0, 8'h20, 8'h10, 1'b1};
    tbl[3] = '{2, 2'b10, 8'h03, 8'h01, 8'h01, 1'b0};
    tbl[4] = '{3, 2'b11, 8'h80, 8'h7F, 8'h02, 1'b0};
    tbl[5] = '{3, 2'b11, 8'h55, 8'h55, 8'h01, 1'b0};
    tbl[6] = '{1, 2'b01, 8'hFF, 8'h01, 8'hFE, 1'b0};
    tbl[7] = '{2, 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1};

    reset_n = 1'b0;
    req = '0;
    req_opcode = '0;
    req_a = '0;
    req_b = '0;
    repeat (3) @(negedge clk);
    check("reset_state",
          {gnt, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy,
           alu_opcode_valid, alu_opcode, alu_data}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // Vector table, first entry also checks the serial beats
    for (int t = 0; t < 8; t++) begin
      beat_log.delete();
      alu_lat = t % 3;
      run_one(tbl[t], $sformatf("vec%0d", t));
      if (t == 0) begin
        check("beat_count", beat_log.size(), 3);
        if (beat_log.size() == 3) begin
          check("beat_hdr", beat_log[0], {1'b0, 8'h00});
          check("beat_a", beat_log[1], {1'b0, 8'h12});
          check("beat_b", beat_log[2], {1'b0, 8'h34});
        end
      end
    end

    // alu_done during the operand beats must be ignored
    alu_glitch = 1'b1;
    alu_lat = 1;
    run_one('{1, 2'b00, 8'h01, 8'h02, 8'h03, 1'b0}, "glitch");
    alu_glitch = 1'b0;

    // Operands are latched at grant
    req = '0;
    set_cmd(2, 2'b01, 8'h40, 8'h11);
    req[2] = 1'b1;
    @(negedge clk);
    wait_gnt(10, nc);
    check("latch_gnt", gnt, 4'b0100);
    @(negedge clk);
    check("latch_beat_a", {alu_opcode_valid, alu_opcode, alu_data},
          {1'b1, 1'b1, 8'h40});
    req = '0;
    set_cmd(2, 2'b00, 8'hAA, 8'h55);
    wait_rsp(40, nc);
    check("latch_rsp", {rsp_valid, rsp_result, rsp_overflow},
          {4'b0100, 8'h2F, 1'b0});
    @(negedge clk);

    // All requesters held: strict rotation from pointer 0
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_cmd(i, 2'(i), 8'(8'h21 * (i + 1)), 8'(8'h13 + i));
    end
    req = '1;
    for (int t = 0; t < 8; t++) begin
      alu_lat = t % 4;
      @(negedge clk);
      wait_rsp(40, nc);
      r = alu_fn(2'(t % N), 8'(8'h21 * (t % N + 1)), 8'(8'h13 + t % N));
      check($sformatf("rot%0d", t),
            {rsp_valid, gnt, rsp_result, rsp_overflow},
            {oh(t % N), oh(t % N), r[W-1:0], r[W]});
    end
    req = '0;
    @(negedge clk);

    // Reset while waiting for the ALU aborts without a response
    do_reset();
    alu_en = 1'b0;
    set_cmd(0, 2'b00, 8'h01, 8'h01);
    req[0] = 1'b1;
    @(negedge clk);
    wait_gnt(10, nc);
    set_cmd(1, 2'b00, 8'h30, 8'h04);
    req[1] = 1'b1;
    repeat (4) @(negedge clk);
    check("wait_state", {busy, alu_opcode_valid, gnt}, {1'b1, 1'b0, 4'b0001});
    reset_n = 1'b0;
    req[0] = 1'b0;
    @(negedge clk);
    check("abort_zero",
          {gnt, rsp_valid, rsp_result, rsp_overflow, rsp_error, busy,
           alu_opcode_valid, alu_opcode, alu_data}, '0);
    reset_n = 1'b1;
    alu_en = 1'b1;
    alu_lat = 0;
    bad = 0;
    nc = 0;
    while (gnt == '0 && nc < 10) begin
      @(negedge clk);
      nc++;
      if (rsp_valid != '0) bad++;
    end
    check("abort_no_rsp", bad, 0);
    check("abort_regrant", gnt, 4'b0010);
    wait_rsp(40, nc);
    check("abort_rsp", {rsp_valid, rsp_result}, {4'b0010, 8'h34});
    req = '0;
    @(negedge clk);

    // ALU never answers
    alu_en = 1'b0;
    set_cmd(0, 2'b00, 8'h07, 8'h08);
    req[0] = 1'b1;
    @(negedge clk);
    wait_gnt(10, nc);
`ifdef ALU_TIMEOUT_EN
    wait_rsp(TMO + 20, nc);
    check("tmo_latency", nc, 3 + TMO);
    check("tmo_rsp",
          {rsp_valid, rsp_result, rsp_overflow, rsp_error},
          {4'b0001, 8'h00, 1'b0, 1'b1});
    req = '0;
    @(negedge clk);
    check("tmo_gap", {gnt, busy}, '0);
`else
    bad = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (!busy || rsp_valid != '0 || gnt != 4'b0001) bad++;
    end
    check("no_tmo_stuck", bad, 0);
`endif
    alu_en = 1'b1;
    do_reset();

    // Randomized traffic against a transaction-level round-robin model
    ptr_m = 0;
    gcur = -1;
    gcyc = 0;
    lat_cur = 0;
    ntx = 0;
    gap_chk = 1'b0;
    prev_req = '0;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      c_op[i] = '0;
      c_a[i] = '0;
      c_b[i] = '0;
    end
    for (int cyc = 0; cyc < 4000 && ntx < 150; cyc++) begin
      @(negedge clk);
      if (gap_chk) begin
        check("rr_gap", {gnt, busy}, '0);
        gap_chk = 1'b0;
      end else if (gcur < 0 && gnt != '0) begin
        exp_i = -1;
        for (int k = 0; k < N; k++) begin
          if (exp_i < 0 && prev_req[(ptr_m + k) % N]) exp_i = (ptr_m + k) % N;
        end
        exp_g = (exp_i < 0) ? '0 : oh(exp_i);
        check("rr_grant", gnt, exp_g);
        gcur = (exp_i < 0) ? 0 : exp_i;
        gcyc = cyc;
        lat_cur = $urandom_range(0, 5);
        alu_lat = lat_cur;
      end
      if (rsp_valid != '0) begin
        if (gcur < 0) begin
          check("rr_unexpected_rsp", rsp_valid, '0);
        end else begin
          r = alu_fn(c_op[gcur], c_a[gcur], c_b[gcur]);
          check("rr_rsp",
                {rsp_valid, gnt, rsp_result, rsp_overflow, rsp_error},
                {oh(gcur), oh(gcur), r[W-1:0], r[W], 1'b0});
          check("rr_lat", cyc - gcyc, lat_cur + 4);
          ptr_m = (gcur + 1) % N;
          act[gcur] = 1'b0;
          gcur = -1;
          gap_chk = 1'b1;
          ntx++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i] = 1'b1;
          c_op[i] = 2'($urandom);
          c_a[i] = W'($urandom);
          c_b[i] = W'($urandom);
        end
        req[i] = act[i];
        set_cmd(i, c_op[i], c_a[i], c_b[i]);
      end
      prev_req = req;
    end
    check("rr_ntx", ntx, 150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
